seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Multi-digit front end for the hex seven-segment decoder. It converts a binary value to BCD with a sequential double-dabble engine and time-multiplexes the digits onto one shared 4-bit digit bus, which feeds the decoder's `in` input directly, plus a one-hot digit-enable bus for the common pins. Every digit it emits is in the range 0–9, which is the decoder's defined range.

## Interface
- `DIGITS`, default 4: number of display digits; must be ≥ 1.
- `WIDTH`, default 14: width of the binary input value.
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; must be ≥ 1.
- `clk` input, 1 bit: the single clock; every flop is on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `load` input, 1 bit: single-cycle request to capture `value`.
- `value` input, WIDTH bits: unsigned binary number to display.
- `busy` output, 1 bit: a conversion is in progress; `load` is ignored while this is high.
- `overflow` output, 1 bit: the last accepted value was ≥ 10^DIGITS.
- `digit` output, 4 bits: BCD code of the currently scanned digit, sent to the decoder.
- `digit_en` output, DIGITS bits: one-hot, active-high; bit k enables digit k, with digit 0 the least significant.

## Operation
- **Reset values:**
  - `busy` = 0, `overflow` = 0.
  - Display BCD register = all zeros, so `digit` = 0.
  - Scan index = 0, so `digit_en` = …0001.
  - Scan counter = 0.
  - FSM in IDLE.
- **FSM states:** IDLE, CONVERT, COMMIT.
  - IDLE: a `load` pulse captures `value` into the shift register and clears the BCD working register. The overflow compare is evaluated on the captured value. Bit counter is set to WIDTH. Transition to CONVERT.
  - CONVERT: one double-dabble step per cycle. Each BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left by 1. After WIDTH steps, transition to COMMIT.
  - COMMIT: the display BCD register loads the working result, or all 9s if overflow. `overflow` updates in the same cycle. Transition to IDLE.
- **Width rules:**
  - The working BCD register is 4*DIGITS bits.
  - Adjust-then-shift keeps every nibble ≤ 9.
  - Bits shifted out of the top are discarded; this only happens when overflow is set, and then the result is replaced by 9s.
- **Display update:** the display register changes only in COMMIT, so a half-converted value is never shown.
- **Scan counter:**
  - Counts 0 to SCAN_DIV−1 and wraps.
  - On wrap, the scan index advances and wraps from DIGITS−1 to 0.
  - Scanning runs continuously and independently of the FSM.
- **Digit outputs:** `digit` is the nibble of the display register selected by the scan index. `digit_en` is the one-hot decode of the scan index. Both are registered and change on the same edge.
- **Boundary cases:**
  - `load` in CONVERT or COMMIT: dropped, with no queueing.
  - `load` in the same cycle as COMMIT: dropped; it is accepted from the next IDLE cycle onward.
  - `value` = 0: displays all zeros, `overflow` = 0.
  - `value` = 10^DIGITS − 1: shown exactly, `overflow` = 0.
  - `value` = 10^DIGITS: all 9s, `overflow` = 1.
  - If WIDTH cannot represent 10^DIGITS, `overflow` never asserts.
  - Reset asserted mid-conversion: immediate return to the reset values. The previous display content is lost.

## Timing
- `load` sampled high in IDLE at edge 0 → `busy` = 1 from edge 0+.
- CONVERT occupies WIDTH cycles, followed by one COMMIT cycle.
- New BCD value and `busy` = 0 are visible after edge WIDTH+1. Total latency is WIDTH+1 cycles; with the default WIDTH = 14, that is 15.
- Next `load` is accepted at the earliest at edge WIDTH+2.
- `digit` / `digit_en` reflect a new display value no later than 1 cycle after COMMIT for the currently scanned digit.
- Scan index advances every SCAN_DIV cycles. A full frame is DIGITS*SCAN_DIV cycles.
- After reset release, the first index advance occurs at the SCAN_DIV-th rising edge.

## Structure
- Shared package `seg_pkg`:
  - `BCD_W` = 4.
  - FSM state enum {IDLE, CONVERT, COMMIT}.
  - Helper function computing 10^DIGITS, used for the overflow compare.
- Sub-module `bin2bcd_seq`:
  - Contains the FSM, the double-dabble datapath and the overflow compare.
  - Ports: `clk`, `rst_n`, `load`, `value`, `busy`, `bcd`, `overflow`, `done`.
- Top level holds the display register, scan counter, scan index and output registers.

## Test plan
All scenarios use DIGITS = 4, WIDTH = 14, SCAN_DIV = 4.
- **Reset:** assert `rst_n` = 0 mid-run → `digit` = 0, `digit_en` = 0001, `busy` = 0, `overflow` = 0, all asynchronously.
- **Normal conversion:** `load` with `value` = 1234 → `busy` high for 15 cycles. Over one frame, `digit` sequence is 4, 3, 2, 1 with `digit_en` sequence 0001, 0010, 0100, 1000, each held 4 cycles.
- **Boundary values:**
  - `value` = 9999 → digits 9, 9, 9, 9, `overflow` = 0.
  - `value` = 10000 → digits 9, 9, 9, 9, `overflow` = 1.
  - `value` = 16383 → digits 9, 9, 9, 9, `overflow` = 1.
  - `value` = 0 → all digits 0.
- **Load while busy:** `load` with 42, then `load` with 77 three cycles later → display shows 0042. The second `load` has no effect.
- **Back-to-back loads:** `load` 5678 at edge 0, then `load` 8765 at edge 16 → display 5678 after edge 15, then 8765 after edge 31. At no cycle does `digit` hold a value outside the committed set.
- **Reset mid-conversion:** assert reset at cycle 7 of converting 4321 → display stays 0000 after release. A subsequent `load` of 4321 displays correctly.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed BCD seven-segment front end.
package seg_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    // 10^n as an unsigned 64-bit constant; the overflow threshold for n digits
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load/value request and multiplexed digit outputs of the scan driver.
interface seg_scan_driver_if
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
);
    logic              load;
    logic [WIDTH-1:0]  value;
    logic              busy;
    logic              overflow;
    logic [BCD_W-1:0]  digit;
    logic [DIGITS-1:0] digit_en;

    modport master (
        output load, value,
        input  busy, overflow, digit, digit_en
    );

    modport slave (
        input  load, value,
        output busy, overflow, digit, digit_en
    );
endinterface

// File: rtl/seg_scan_driver_bin2bcd.sv
// Sequential double-dabble converter: one adjust-and-shift step per cycle,
// with an overflow compare so out-of-range values commit as all nines.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [WIDTH-1:0]          value,
    output logic                      busy,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      overflow,
    output logic                      done
);

    localparam int          BW    = BCD_W * DIGITS;
    localparam int          CW    = $clog2(WIDTH + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    state_t              state_q;
    logic [WIDTH-1:0]    bin_q;
    logic [BW-1:0]       work_q;
    logic [CW-1:0]       cnt_q;
    logic                ovfPend_q;
    logic                busy_q;
    logic                overflow_q;
    logic                done_q;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;
    logic                tooBig;

    // When WIDTH cannot reach 10^DIGITS this compare is constant false
    assign tooBig = (64'(value) >= LIMIT);

    always_comb begin
        adj = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[k*BCD_W +: BCD_W] >= 4'd5) begin
                adj[k*BCD_W +: BCD_W] = work_q[k*BCD_W +: BCD_W] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovfPend_q  <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        bin_q     <= value;
                        work_q    <= '0;
                        cnt_q     <= CW'(WIDTH);
                        ovfPend_q <= tooBig;
                        busy_q    <= 1'b1;
                        state_q   <= CONVERT;
                    end
                end
                CONVERT: begin
                    {work_q, bin_q} <= shifted;
                    cnt_q           <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= COMMIT;
                        done_q  <= 1'b1;
                    end
                end
                COMMIT: begin
                    overflow_q <= ovfPend_q;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign done     = done_q;
    assign bcd      = ovfPend_q ? {DIGITS{4'h9}} : work_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multi-digit display front end: holds the committed BCD value and scans its
// digits one at a time onto a shared digit bus with a one-hot enable.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 14,
    parameter int SCAN_DIV = 50000
) (
    input logic               clk,
    input logic               rst_n,
    seg_scan_driver_if.slave  bus
);

    localparam int BW = BCD_W * DIGITS;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [BW-1:0]     bcd;
    logic              done;

    logic [BW-1:0]     display_q, display_d;
    logic [SW-1:0]     scanCnt_q, scanCnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [BCD_W-1:0]  digit_q, digit_d;
    logic [DIGITS-1:0] digitEn_q, digitEn_d;
    logic              scanWrap;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .WIDTH  (WIDTH)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bus.load),
        .value    (bus.value),
        .busy     (bus.busy),
        .bcd      (bcd),
        .overflow (bus.overflow),
        .done     (done)
    );

    // Outputs are built from next-state values so a fresh commit reaches the
    // digit bus on the same edge that updates the display register.
    always_comb begin
        display_d = done ? bcd : display_q;
        scanWrap  = (scanCnt_q == SW'(SCAN_DIV - 1));
        scanCnt_d = scanWrap ? '0 : scanCnt_q + SW'(1);
        idx_d     = idx_q;
        if (scanWrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        digit_d   = display_d[BCD_W*idx_d +: BCD_W];
        digitEn_d = DIGITS'(1) << idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q <= '0;
            scanCnt_q <= '0;
            idx_q     <= '0;
            digit_q   <= '0;
            digitEn_q <= DIGITS'(1);
        end else begin
            display_q <= display_d;
            scanCnt_q <= scanCnt_d;
            idx_q     <= idx_d;
            digit_q   <= digit_d;
            digitEn_q <= digitEn_d;
        end
    end

    assign bus.digit    = digit_q;
    assign bus.digit_en = digitEn_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, WIDTH=14, SCAN_DIV=4.
module tb_seg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int WIDTH    = 14;
    localparam int SCAN_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg_scan_driver_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

    seg_scan_driver #(
        .DIGITS   (DIGITS),
        .WIDTH    (WIDTH),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nib(input logic [15:0] w, input int k);
        return w[4*k +: 4];
    endfunction

    function automatic int enIndex(input logic [3:0] en);
        int idx;
        int ones;
        idx  = -1;
        ones = 0;
        for (int b = 0; b < 4; b++) begin
            if (en[b] === 1'b1) begin
                idx = b;
                ones++;
            end
        end
        return (ones == 1) ? idx : -1;
    endfunction

    // Pulses load for one edge, then counts cycles with busy high
    task automatic start_conversion(input logic [WIDTH-1:0] v, output int busyCycles,
                                    output bit timedOut);
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load   = 1'b0;
        busyCycles = 0;
        timedOut   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (bus.busy !== 1'b1) begin
                timedOut = 1'b0;
                break;
            end
            busyCycles++;
            @(negedge clk);
        end
    endtask

    // Aligns to the start of a frame and records one nibble per digit slot
    task automatic capture_frame(output logic [15:0] seen, output bit seqOk,
                                 output bit timedOut);
        bit sawLast;
        sawLast  = 1'b0;
        seqOk    = 1'b1;
        timedOut = 1'b1;
        seen     = '0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (sawLast && bus.digit_en === 4'b0001) begin
                timedOut = 1'b0;
                break;
            end
            if (bus.digit_en === 4'b1000) sawLast = 1'b1;
        end
        if (!timedOut) begin
            for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
                if (i > 0) @(negedge clk);
                if (bus.digit_en !== (4'b0001 << (i / SCAN_DIV))) seqOk = 1'b0;
                if (i % SCAN_DIV == 0) seen[4*(i/SCAN_DIV) +: 4] = bus.digit;
                else if (bus.digit !== seen[4*(i/SCAN_DIV) +: 4]) seqOk = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bus.load  = 1'b0;
        bus.value = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.digit !== 4'd0 || bus.digit_en !== 4'b0001 ||
            bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: digit=%h en=%b busy=%b ovf=%b expected 0 0001 0 0",
                     bus.digit, bus.digit_en, bus.busy, bus.overflow);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int busyCycles;
        bit tmo;
        bit seqOk;
        logic [15:0] seen;
        start_conversion(14'd1234, busyCycles, tmo);
        checks++;
        if (tmo || busyCycles != 15) begin
            errors++;
            $display("[TB] FAIL normal_busy_len: got %0d cycles (timeout=%0b) expected 15", busyCycles, tmo);
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL normal_overflow: got %b expected 0", bus.overflow);
        end
        capture_frame(seen, seqOk, tmo);
        checks++;
        if (tmo || !seqOk) begin
            errors++;
            $display("[TB] FAIL normal_scan_seq: timeout=%0b seqOk=%0b expected 0 1", tmo, seqOk);
        end
        checks++;
        if (seen !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL normal_digits: got %h expected 1234", seen);
        end
    endtask

    task automatic test_boundary();
        logic [WIDTH-1:0] vals [4];
        logic [15:0]      expBcd [4];
        logic             expOvf [4];
        int busyCycles;
        bit tmo;
        bit seqOk;
        logic [15:0] seen;
        vals[0] = 14'd9999;  expBcd[0] = 16'h9999; expOvf[0] = 1'b0;
        vals[1] = 14'd10000; expBcd[1] = 16'h9999; expOvf[1] = 1'b1;
        vals[2] = 14'd16383; expBcd[2] = 16'h9999; expOvf[2] = 1'b1;
        vals[3] = 14'd0;     expBcd[3] = 16'h0000; expOvf[3] = 1'b0;
        for (int t = 0; t < 4; t++) begin
            start_conversion(vals[t], busyCycles, tmo);
            checks++;
            if (tmo || bus.overflow !== expOvf[t]) begin
                errors++;
                $display("[TB] FAIL boundary_ovf_%0d: got %b (timeout=%0b) expected %b",
                         vals[t], bus.overflow, tmo, expOvf[t]);
            end
            capture_frame(seen, seqOk, tmo);
            checks++;
            if (tmo || !seqOk || seen !== expBcd[t]) begin
                errors++;
                $display("[TB] FAIL boundary_digits_%0d: got %h (seqOk=%0b) expected %h",
                         vals[t], seen, seqOk, expBcd[t]);
            end
        end
    endtask

    task automatic test_async_reset();
        int busyCycles;
        bit tmo;
        bit seqOk;
        logic [15:0] seen;
        start_conversion(14'd10000, busyCycles, tmo);
        capture_frame(seen, seqOk, tmo);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.digit !== 4'd0 || bus.digit_en !== 4'b0001 ||
            bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: digit=%h en=%b busy=%b ovf=%b expected 0 0001 0 0",
                     bus.digit, bus.digit_en, bus.busy, bus.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_while_busy();
        int busyCycles;
        bit tmo;
        bit seqOk;
        logic [15:0] seen;
        // second load three edges into the conversion must be dropped
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 14'd42;
        busyCycles = 0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.load = (i == 2);
            if (i == 2) bus.value = 14'd77;
            if (bus.busy !== 1'b1) begin
                tmo = 1'b0;
                break;
            end
            busyCycles++;
        end
        checks++;
        if (tmo || busyCycles != 15) begin
            errors++;
            $display("[TB] FAIL busy_drop_len: got %0d (timeout=%0b) expected 15", busyCycles, tmo);
        end
        capture_frame(seen, seqOk, tmo);
        checks++;
        if (tmo || !seqOk || seen !== 16'h0042) begin
            errors++;
            $display("[TB] FAIL busy_drop_digits: got %h (seqOk=%0b) expected 0042", seen, seqOk);
        end
        // a load landing on the commit edge is also dropped
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 14'd300;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            bus.load = (i == 14);
            if (i == 14) bus.value = 14'd555;
            if (i == 15 || i == 16) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL commit_drop_busy_%0d: got %b expected 0", i, bus.busy);
                end
            end
        end
        capture_frame(seen, seqOk, tmo);
        checks++;
        if (tmo || !seqOk || seen !== 16'h0300) begin
            errors++;
            $display("[TB] FAIL commit_drop_digits: got %h (seqOk=%0b) expected 0300", seen, seqOk);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expW;
        int k;
        bit seqOk;
        bit tmo;
        logic [15:0] seen;
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 14'd5678;
        for (int i = 0; i <= 33; i++) begin
            @(negedge clk);
            bus.load = (i == 15);
            if (i == 15) bus.value = 14'd8765;
            expW = (i < 15) ? 16'h0300 : ((i < 31) ? 16'h5678 : 16'h8765);
            k = enIndex(bus.digit_en);
            checks++;
            if (k < 0 || bus.digit !== nib(expW, k)) begin
                errors++;
                $display("[TB] FAIL b2b_digit_cycle_%0d: got digit=%h en=%b expected nibble of %h",
                         i, bus.digit, bus.digit_en, expW);
            end
            if (i == 15 || i == 16 || i == 31) begin
                checks++;
                if (bus.busy !== (i == 16)) begin
                    errors++;
                    $display("[TB] FAIL b2b_busy_cycle_%0d: got %b expected %b", i, bus.busy, (i == 16));
                end
            end
        end
        capture_frame(seen, seqOk, tmo);
        checks++;
        if (tmo || !seqOk || seen !== 16'h8765) begin
            errors++;
            $display("[TB] FAIL b2b_final_digits: got %h (seqOk=%0b) expected 8765", seen, seqOk);
        end
    endtask

    task automatic test_reset_mid();
        int busyCycles;
        bit tmo;
        bit seqOk;
        logic [15:0] seen;
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 14'd4321;
        @(negedge clk);
        bus.load = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state: busy=%b ovf=%b expected 0 0", bus.busy, bus.overflow);
        end
        capture_frame(seen, seqOk, tmo);
        checks++;
        if (tmo || !seqOk || seen !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midreset_digits: got %h (seqOk=%0b) expected 0000", seen, seqOk);
        end
        start_conversion(14'd4321, busyCycles, tmo);
        checks++;
        if (tmo || busyCycles != 15) begin
            errors++;
            $display("[TB] FAIL midreset_reload_busy: got %0d (timeout=%0b) expected 15", busyCycles, tmo);
        end
        capture_frame(seen, seqOk, tmo);
        checks++;
        if (tmo || !seqOk || seen !== 16'h4321) begin
            errors++;
            $display("[TB] FAIL midreset_reload_digits: got %h (seqOk=%0b) expected 4321", seen, seqOk);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_boundary();
        test_async_reset();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
